// File: rtl/reset_seq_ctrl_pkg.sv
// ============================================================================
// Module  : reset_seq_pkg
// Brief   : Shared states, widths and default parameters for reset_seq_ctrl.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package reset_seq_pkg;

    typedef enum logic [2:0] {
        HOLD    = 3'd0,
        STRETCH = 3'd1,
        MEM_REL = 3'd2,
        RUN     = 3'd3,
        HALT    = 3'd4,
        TIMEOUT = 3'd5
    } state_e;

    localparam int RETIRE_W = 32;

    localparam int          SYNC_STAGES_DEF    = 2;
    localparam int          STRETCH_CYCLES_DEF = 16;
    localparam int          STAGGER_CYCLES_DEF = 4;
    localparam int          WDT_WIDTH_DEF      = 24;
    localparam logic [23:0] WDT_LIMIT_DEF      = 24'hFFFFFF;

endpackage

`default_nettype wire

// File: rtl/reset_seq_ctrl_if.sv
// ============================================================================
// Module  : reset_seq_ctrl_if
// Brief   : Core-side handshake and status bundle for reset_seq_ctrl.
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface reset_seq_ctrl_if;
    import reset_seq_pkg::*;

    logic                inst_done;
    logic                halt_req;
    logic                rst_mem;
    logic                rst_core;
    logic                running;
    logic                halted;
    logic                wdt_timeout;
    logic [RETIRE_W-1:0] retire_cnt;

    // master drives the core events and observes status (bench / core side)
    modport master (
        output inst_done, halt_req,
        input  rst_mem, rst_core, running, halted, wdt_timeout, retire_cnt
    );

    modport slave (
        input  inst_done, halt_req,
        output rst_mem, rst_core, running, halted, wdt_timeout, retire_cnt
    );

endinterface

`default_nettype wire

// File: rtl/reset_seq_ctrl_reset_sync.sv
// ============================================================================
// Module  : reset_sync
// Brief   : Async-assert / sync-deassert reset flop chain.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module reset_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic clock,
    input  wire logic reset,
    output logic      rst_sync_o
);

    logic [SYNC_STAGES-1:0] chain_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            chain_q <= '1;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], 1'b0};
        end
    end

    assign rst_sync_o = chain_q[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/reset_seq_ctrl.sv
// ============================================================================
// Module  : reset_seq_ctrl
// Brief   : Staggered memory/core reset release plus run/halt/watchdog
//           supervision. Optional trace build: RESET_SEQ_TRACE_EN.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module reset_seq_ctrl
    import reset_seq_pkg::*;
#(
    parameter int                   SYNC_STAGES    = SYNC_STAGES_DEF,
    parameter int                   STRETCH_CYCLES = STRETCH_CYCLES_DEF,
    parameter int                   STAGGER_CYCLES = STAGGER_CYCLES_DEF,
    parameter int                   WDT_WIDTH      = WDT_WIDTH_DEF,
    parameter logic [WDT_WIDTH-1:0] WDT_LIMIT      = WDT_WIDTH'(WDT_LIMIT_DEF)
) (
    input  wire logic         clock,
    input  wire logic         reset,
    reset_seq_ctrl_if.slave   bus
);

    localparam int SEQ_MAX = (STRETCH_CYCLES > STAGGER_CYCLES) ? STRETCH_CYCLES : STAGGER_CYCLES;
    localparam int SEQ_W   = $clog2(SEQ_MAX + 1);

    logic                 rst_sync;
    state_e               state_q,       state_d;
    logic [SEQ_W-1:0]     seq_cnt_q,     seq_cnt_d;
    logic [WDT_WIDTH-1:0] idle_q,        idle_d;
    logic [RETIRE_W-1:0]  retire_q,      retire_d;
    logic                 rst_mem_q,     rst_mem_d;
    logic                 rst_core_q,    rst_core_d;
    logic                 running_q,     running_d;
    logic                 halted_q,      halted_d;
    logic                 wdt_timeout_q, wdt_timeout_d;

    reset_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_reset_sync (
        .clock      (clock),
        .reset      (reset),
        .rst_sync_o (rst_sync)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= HOLD;
            seq_cnt_q     <= '0;
            idle_q        <= '0;
            retire_q      <= '0;
            rst_mem_q     <= 1'b1;
            rst_core_q    <= 1'b1;
            running_q     <= 1'b0;
            halted_q      <= 1'b0;
            wdt_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            seq_cnt_q     <= seq_cnt_d;
            idle_q        <= idle_d;
            retire_q      <= retire_d;
            rst_mem_q     <= rst_mem_d;
            rst_core_q    <= rst_core_d;
            running_q     <= running_d;
            halted_q      <= halted_d;
            wdt_timeout_q <= wdt_timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        seq_cnt_d     = seq_cnt_q;
        idle_d        = idle_q;
        retire_d      = retire_q;
        rst_mem_d     = rst_mem_q;
        rst_core_d    = rst_core_q;
        running_d     = running_q;
        halted_d      = halted_q;
        wdt_timeout_d = wdt_timeout_q;

        case (state_q)
            // The edge that sees the synchronizer low is already the first stretch edge.
            HOLD: begin
                if (!rst_sync) begin
                    state_d   = STRETCH;
                    seq_cnt_d = SEQ_W'(1);
                end
            end
            STRETCH: begin
                if (seq_cnt_q >= SEQ_W'(STRETCH_CYCLES - 1)) begin
                    state_d   = MEM_REL;
                    seq_cnt_d = '0;
                    rst_mem_d = 1'b0;
                end else begin
                    seq_cnt_d = seq_cnt_q + SEQ_W'(1);
                end
            end
            MEM_REL: begin
                if (seq_cnt_q >= SEQ_W'(STAGGER_CYCLES - 1)) begin
                    state_d    = RUN;
                    rst_core_d = 1'b0;
                    running_d  = 1'b1;
                end else begin
                    seq_cnt_d = seq_cnt_q + SEQ_W'(1);
                end
            end
            RUN: begin
                if (bus.inst_done && (retire_q != '1)) begin
                    retire_d = retire_q + RETIRE_W'(1);
                end
                // Halt outranks the watchdog; a retirement on the expiry edge rescues it.
                if (bus.halt_req) begin
                    state_d   = HALT;
                    halted_d  = 1'b1;
                    running_d = 1'b0;
                end else if (bus.inst_done) begin
                    idle_d = '0;
                end else if (idle_q == WDT_LIMIT) begin
                    state_d       = TIMEOUT;
                    wdt_timeout_d = 1'b1;
                    running_d     = 1'b0;
                    rst_core_d    = 1'b1;
                end else begin
                    idle_d = idle_q + WDT_WIDTH'(1);
                end
            end
            default: ;
        endcase
    end

    assign bus.rst_mem     = rst_mem_q;
    assign bus.rst_core    = rst_core_q;
    assign bus.running     = running_q;
    assign bus.halted      = halted_q;
    assign bus.wdt_timeout = wdt_timeout_q;
    assign bus.retire_cnt  = retire_q;

`ifdef RESET_SEQ_TRACE_EN
    logic [63:0] cycle_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 64'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && (state_d != state_q)) begin
            $display("[reset_seq_ctrl] cycle %0d -> %s", cycle_q + 64'd1, state_d.name());
            if ((state_d == HALT) || (state_d == TIMEOUT)) begin
                $display("[reset_seq_ctrl] retire_cnt %0d ipc_x100 %0d", retire_d,
                         (64'(retire_d) * 64'd100) / (cycle_q + 64'd1));
            end
        end
    end
`else
    // Netlist build: no cycle counter and no trace output.
`endif

endmodule

`default_nettype wire

// File: tb/tb_reset_seq_ctrl.sv
// ============================================================================
// Module  : tb_reset_seq_ctrl
// Brief   : Directed + randomized bench for reset_seq_ctrl against an
//           edge-count reference model (WDT_LIMIT reduced to 100).
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_reset_seq_ctrl;

    localparam int          T_MEM   = 2 + 16;
    localparam int          T_RUN   = 2 + 16 + 4;
    localparam int          LIMIT   = 100;
    localparam logic [31:0] SAT_MAX = 32'hFFFF_FFFF;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int checks = 0;
    int errors = 0;

    // Reference model: edges since reset release plus sticky run-phase facts.
    int          rel;
    bit          m_halt;
    bit          m_to;
    int          idle;
    logic [31:0] m_ret;

    reset_seq_ctrl_if bus ();

    reset_seq_ctrl #(
        .SYNC_STAGES    (2),
        .STRETCH_CYCLES (16),
        .STAGGER_CYCLES (4),
        .WDT_WIDTH      (24),
        .WDT_LIMIT      (24'd100)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        rel    = 0;
        m_halt = 1'b0;
        m_to   = 1'b0;
        idle   = 0;
        m_ret  = '0;
    endtask

    task automatic model_edge(input bit inst, input bit halt);
        if (rel >= T_RUN && !m_halt && !m_to) begin
            if (inst && m_ret != SAT_MAX) m_ret = m_ret + 32'd1;
            if (halt)               m_halt = 1'b1;
            else if (inst)          idle = 0;
            else if (idle == LIMIT) m_to = 1'b1;
            else                    idle++;
        end
        if (rel < 1000000) rel++;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rst_mem"},     32'(bus.rst_mem),     32'(rel < T_MEM));
        chk({tag, ".rst_core"},    32'(bus.rst_core),    32'((rel < T_RUN) || m_to));
        chk({tag, ".running"},     32'(bus.running),     32'((rel >= T_RUN) && !m_halt && !m_to));
        chk({tag, ".halted"},      32'(bus.halted),      32'(m_halt));
        chk({tag, ".wdt_timeout"}, 32'(bus.wdt_timeout), 32'(m_to));
        chk({tag, ".retire_cnt"},  bus.retire_cnt,       m_ret);
    endtask

    task automatic tick(input bit inst, input bit halt);
        bus.inst_done = inst;
        bus.halt_req  = halt;
        @(posedge clock);
        if (!reset) model_edge(inst, halt);
        #1;
        check_all("tick");
    endtask

    task automatic assert_reset(input int cycles);
        @(negedge clock);
        reset         = 1'b1;
        bus.inst_done = 1'b0;
        bus.halt_req  = 1'b0;
        model_clear();
        #1;
        check_all("async_rst");
        for (int i = 0; i < cycles; i++) tick(1'b1, 1'b0);
    endtask

    // Release mid-low-phase and walk the 22-edge sequence; inst_done on even
    // edges 14..22 lands before the core is out of reset and must be ignored.
    task automatic release_seq();
        @(negedge clock);
        #2;
        reset = 1'b0;
        for (int e = 1; e <= T_RUN; e++) begin
            tick((e >= 14) && (e % 2 == 0), 1'b0);
            if (e == 17) chk("rst_mem_e17",  32'(bus.rst_mem),  32'd1);
            if (e == 18) chk("rst_mem_e18",  32'(bus.rst_mem),  32'd0);
            if (e == 21) chk("rst_core_e21", 32'(bus.rst_core), 32'd1);
            if (e == 22) begin
                chk("rst_core_e22", 32'(bus.rst_core),   32'd0);
                chk("running_e22",  32'(bus.running),    32'd1);
                chk("early_inst",   bus.retire_cnt,      32'd0);
            end
        end
    endtask

    initial begin
        bus.inst_done = 1'b0;
        bus.halt_req  = 1'b0;
        model_clear();

        // Power-on
        for (int i = 0; i < 50; i++) tick(1'b1, 1'b0);
        release_seq();

        // Random retirement until 1000, then a mixed random phase
        for (int i = 0; i < 5000 && m_ret < 1000; i++) tick(1'($urandom % 2), 1'b0);
        chk("retire_1000", bus.retire_cnt, 32'd1000);
        for (int i = 0; i < 200; i++) tick(1'($urandom % 2), 1'b0);

        // Mid-run reset
        assert_reset(3);
        chk("midrun_retire", bus.retire_cnt, 32'd0);
        release_seq();

        // Watchdog: rescue at idle edge 100, rescue at expiry edge, then expire
        for (int i = 0; i < 99; i++) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        for (int i = 0; i < 100; i++) tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        chk("wdt_rescued", 32'(bus.wdt_timeout), 32'd0);
        for (int i = 0; i < 100; i++) tick(1'b0, 1'b0);
        chk("wdt_edge100", 32'(bus.wdt_timeout), 32'd0);
        tick(1'b0, 1'b0);
        chk("wdt_edge101",   32'(bus.wdt_timeout), 32'd1);
        chk("wdt_rst_core",  32'(bus.rst_core),    32'd1);
        chk("wdt_rst_mem",   32'(bus.rst_mem),     32'd0);
        for (int i = 0; i < 5; i++) tick(1'($urandom % 2), 1'($urandom % 2));

        // Halt after 37 retirements
        assert_reset(2);
        release_seq();
        for (int i = 0; i < 500 && m_ret < 37; i++) tick(1'($urandom % 2), 1'b0);
        tick(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) tick(1'($urandom % 2), 1'b0);
        chk("halt_halted",   32'(bus.halted),   32'd1);
        chk("halt_running",  32'(bus.running),  32'd0);
        chk("halt_retire",   bus.retire_cnt,    32'd37);
        chk("halt_rst_core", 32'(bus.rst_core), 32'd0);

        // Halt coincident with watchdog expiry
        assert_reset(2);
        release_seq();
        for (int i = 0; i < 100; i++) tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        chk("halt_wdt_halted", 32'(bus.halted),      32'd1);
        chk("halt_wdt_to",     32'(bus.wdt_timeout), 32'd0);

        // Saturation
        assert_reset(2);
        release_seq();
        @(negedge clock);
        force dut.retire_q = 32'hFFFF_FFFE;
        #1;
        release dut.retire_q;
        m_ret = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        chk("sat_hold", bus.retire_cnt, SAT_MAX);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
